uart_tx_frame: RTL and testbench

- UART transmitter: serialises a parallel word into one asynchronous frame (start, data LSB-first, optional parity, stop) on a single serial line.
- TX-side counterpart of the UART RX path, with identical parity semantics.
- Lives in the TX clock domain; tx_clk runs at the baud rate, so one bit is sent per tx_clk cycle.
- Fed by the system-side data path through a valid/ready handshake.

---
 rtl/uart_tx_frame_if.sv | 20 ++
 rtl/uart_tx_frame.sv | 148 ++++++++++++++
 tb/tb_uart_tx_frame.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_frame_if.sv
// System-side valid/ready handshake into the UART transmitter: word, parity config, ready.
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  parity_enable;
  logic                  parity_type;
  logic                  tx_ready;

  modport master (
    output p_data, data_valid, parity_enable, parity_type,
    input  tx_ready
  );

  modport slave (
    input  p_data, data_valid, parity_enable, parity_type,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: one frame (start, LSB-first data, optional parity, stop) per accepted word.
// Optional macro UART_TX_DATA_BUF_EN adds a one-entry holding buffer for back-to-back frames.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic           tx_clk,
  input  logic           rst,
  uart_tx_frame_if.slave s,
  output logic           tx_out,
  output logic           busy
);
  localparam int CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state, state_nx;
  logic [CW-1:0]         cnt, cnt_nx;
  logic                  tx_nx, busy_nx;
  logic                  accept, load_in, load_buf;
  logic                  hold_vld;
  logic [DATA_WIDTH-1:0] frame_data, shifted;
  logic                  frame_par_en, frame_par_odd;

  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return odd ? ~^d : ^d;
  endfunction

  assign accept  = s.data_valid && s.tx_ready;
  assign shifted = frame_data >> cnt;

`ifdef UART_TX_DATA_BUF_EN
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_par_en, hold_par_odd;

  assign s.tx_ready = ~hold_vld;

  // A word accepted while a frame is on the line waits here until STOP exits.
  always_ff @(posedge tx_clk) begin
    if (rst)                  hold_vld <= 1'b0;
    else if (accept && busy)  hold_vld <= 1'b1;
    else if (load_buf)        hold_vld <= 1'b0;
  end

  always_ff @(posedge tx_clk) begin
    if (accept && busy) begin
      hold_data    <= s.p_data;
      hold_par_en  <= s.parity_enable;
      hold_par_odd <= s.parity_type;
    end
  end
`else
  assign hold_vld   = 1'b0;
  assign s.tx_ready = ~busy;
`endif

  // Frame registers are captured once per frame, so later input changes cannot leak in.
  always_ff @(posedge tx_clk) begin
    if (load_in) begin
      frame_data    <= s.p_data;
      frame_par_en  <= s.parity_enable;
      frame_par_odd <= s.parity_type;
    end
`ifdef UART_TX_DATA_BUF_EN
    else if (load_buf) begin
      frame_data    <= hold_data;
      frame_par_en  <= hold_par_en;
      frame_par_odd <= hold_par_odd;
    end
`endif
  end

  always_ff @(posedge tx_clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      tx_out <= 1'b1;
      busy   <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      tx_out <= tx_nx;
      busy   <= busy_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    tx_nx    = tx_out;
    busy_nx  = busy;
    load_in  = 1'b0;
    load_buf = 1'b0;
    case (state)
      IDLE: begin
        tx_nx    = 1'b1;
        busy_nx  = 1'b0;
        load_buf = hold_vld;
        load_in  = accept && !hold_vld;
        if (load_buf || load_in) begin
          state_nx = START;
          tx_nx    = 1'b0;
          busy_nx  = 1'b1;
        end
      end
      START: begin
        state_nx = DATA;
        tx_nx    = frame_data[0];
        cnt_nx   = CW'(1);
      end
      DATA: begin
        // cnt equals DATA_WIDTH once the last data bit has been on the line for a cycle.
        if (cnt == CW'(DATA_WIDTH)) begin
          cnt_nx = '0;
          if (frame_par_en) begin
            state_nx = PARITY;
            tx_nx    = parity_bit(frame_data, frame_par_odd);
          end else begin
            state_nx = STOP;
            tx_nx    = 1'b1;
          end
        end else begin
          tx_nx  = shifted[0];
          cnt_nx = cnt + CW'(1);
        end
      end
      PARITY: begin
        state_nx = STOP;
        tx_nx    = 1'b1;
      end
      STOP: begin
        state_nx = IDLE;
        tx_nx    = 1'b1;
        busy_nx  = 1'b0;
        if (hold_vld) begin
          load_buf = 1'b1;
          state_nx = START;
          tx_nx    = 1'b0;
          busy_nx  = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        tx_nx    = 1'b1;
        busy_nx  = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: directed frames plus random traffic against a bit-queue line model.
module tb_uart_tx_frame;
  logic tx_clk;
  logic rst;
  logic tx_out;
  logic busy;

  uart_tx_frame_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .tx_clk (tx_clk),
    .rst    (rst),
    .s      (bus),
    .tx_out (tx_out),
    .busy   (busy)
  );

  initial tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  int tests = 0;
  int fails = 0;

  // Line model: the bits still to appear on tx_out, one per clock, plus the holding slot.
  bit line_q[$];
  bit hold_q[$];
  bit frm_q[$];
  bit hold_full = 1'b0;
  bit exp_tx    = 1'b1;
  bit exp_busy  = 1'b0;
  bit last_acc  = 1'b0;

  task automatic build_frame(input logic [7:0] d, input logic pe, input logic pt);
    int ones;
    frm_q.delete();
    frm_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) frm_q.push_back(d[i]);
    ones = $countones(d);
    if (pe) frm_q.push_back(pt ? ((ones % 2) == 0) : ((ones % 2) == 1));
    frm_q.push_back(1'b1);
  endtask

  function automatic bit exp_ready();
`ifdef UART_TX_DATA_BUF_EN
    return !hold_full;
`else
    return !exp_busy;
`endif
  endfunction

  task automatic model_edge();
    bit acc;
    acc = bus.data_valid && exp_ready();
    last_acc = acc && !rst;
    if (rst) begin
      line_q.delete();
      hold_q.delete();
      hold_full = 1'b0;
      exp_tx    = 1'b1;
      exp_busy  = 1'b0;
      return;
    end
    if (line_q.size() == 0 && hold_full) begin
      line_q    = hold_q;
      hold_full = 1'b0;
    end
    if (acc) begin
      build_frame(bus.p_data, bus.parity_enable, bus.parity_type);
      if (exp_busy) begin
        hold_q    = frm_q;
        hold_full = 1'b1;
      end else begin
        line_q = frm_q;
      end
    end
    if (line_q.size() > 0) begin
      exp_tx   = line_q.pop_front();
      exp_busy = 1'b1;
    end else begin
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic act, input logic exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: got %b expected %b at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge tx_clk);
    #1;
    chk("tx_out", tx_out, exp_tx);
    chk("busy", busy, exp_busy);
    chk("tx_ready", bus.tx_ready, exp_ready());
  endtask

  // One-cycle valid, then capture n line cycles; optionally scramble inputs mid-frame.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt, input int n,
                            input bit scramble, output logic [15:0] cap, output int nbusy);
    cap   = '0;
    nbusy = 0;
    bus.p_data        = d;
    bus.parity_enable = pe;
    bus.parity_type   = pt;
    bus.data_valid    = 1'b1;
    for (int i = 0; i < n + 2; i++) begin
      step();
      if (i < 16) cap[i] = tx_out;
      if (busy === 1'b1) nbusy++;
      bus.data_valid = 1'b0;
      if (scramble) begin
        bus.p_data        = 8'($urandom);
        bus.parity_enable = ~bus.parity_enable;
        bus.parity_type   = ~bus.parity_type;
      end
    end
  endtask

  initial begin
    logic [15:0] cap;
    int          nbusy;
    logic [7:0]  words[4];
    logic        pes[4];
    logic        pts[4];
    int          idx;

    rst = 1'b1;
    bus.data_valid    = 1'b0;
    bus.p_data        = 8'h00;
    bus.parity_enable = 1'b0;
    bus.parity_type   = 1'b0;
    step();
    step();
    rst = 1'b0;
    repeat (5) step();

    send_frame(8'hA5, 1'b1, 1'b0, 11, 1'b0, cap, nbusy);
    chk_vec("a5_even_bits", {5'b0, cap[10:0]}, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0});
    chk_vec("a5_even_busy", 16'(nbusy), 16'd11);

    send_frame(8'hA5, 1'b1, 1'b1, 11, 1'b0, cap, nbusy);
    chk_vec("a5_odd_bits", {5'b0, cap[10:0]}, {5'b0, 1'b1, 1'b1, 8'hA5, 1'b0});

    send_frame(8'h01, 1'b0, 1'b0, 10, 1'b1, cap, nbusy);
    chk_vec("x01_scrambled_bits", {6'b0, cap[9:0]}, {6'b0, 1'b1, 8'h01, 1'b0});
    chk_vec("x01_busy", 16'(nbusy), 16'd10);
    bus.data_valid = 1'b0;
    step();

    // Valid held high across frames: each word must be sent exactly once.
    for (int i = 0; i < 4; i++) begin
      words[i] = 8'($urandom);
      pes[i]   = 1'($urandom);
      pts[i]   = 1'($urandom);
    end
    idx = 0;
    bus.p_data = words[0]; bus.parity_enable = pes[0]; bus.parity_type = pts[0];
    bus.data_valid = 1'b1;
    for (int c = 0; c < 200 && idx < 4; c++) begin
      step();
      if (last_acc) begin
        idx++;
        if (idx < 4) begin
          bus.p_data = words[idx]; bus.parity_enable = pes[idx]; bus.parity_type = pts[idx];
        end else begin
          bus.data_valid = 1'b0;
        end
      end
    end
    bus.data_valid = 1'b0;
    chk("held_valid_all_accepted", idx == 4, 1'b1);
    repeat (14) step();

    // Reset during the 4th data bit of a 0x00 frame.
    bus.p_data = 8'h00; bus.parity_enable = 1'b0; bus.data_valid = 1'b1;
    step();
    bus.data_valid = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    chk("reset_mid_tx", tx_out, 1'b1);
    chk("reset_mid_busy", busy, 1'b0);
    rst = 1'b0;
    step();
    send_frame(8'hFF, 1'b1, 1'b0, 11, 1'b0, cap, nbusy);
    chk_vec("ff_after_reset", {5'b0, cap[10:0]}, {5'b0, 1'b1, 1'b0, 8'hFF, 1'b0});

`ifdef UART_TX_DATA_BUF_EN
    // Second word accepted while busy must follow the first with no idle cycle.
    bus.p_data = 8'h3C; bus.parity_enable = 1'b0; bus.data_valid = 1'b1;
    step();
    bus.p_data = 8'hC3;
    step();
    bus.data_valid = 1'b0;
    chk("buf_ready_low", bus.tx_ready, 1'b0);
    for (int i = 0; i < 18; i++) begin
      step();
      chk("buf_busy_b2b", busy, 1'b1);
    end
    repeat (4) step();
`endif

    // Random traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      bus.data_valid    = ($urandom % 4) == 0;
      bus.p_data        = 8'($urandom);
      bus.parity_enable = 1'($urandom);
      bus.parity_type   = 1'($urandom);
      rst               = ($urandom % 150) == 0;
      step();
    end
    rst = 1'b0;
    bus.data_valid = 1'b0;
    repeat (30) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
